// File: rtl/axis_bram_adapter_v1_0_s00_axis.sv
// AXIS slave to word-addressed BRAM write port through a small FIFO; 1-cycle min latency, TREADY low when FIFO full or draining.
// Optional: AXIS_BRAM_ADAPTER_S00_TSTRB_MASK_EN zeroes unstrobed bytes and flags partial non-last beats on STRB_ERR.
module axis_bram_adapter_v1_0_s00_axis #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_S_FIFO_DEPTH       = 4,
    parameter int C_S_ADDR_WIDTH       = 10,
    parameter int C_S_MAX_WORDS        = 1024
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DOUT_DATA,
    output logic [C_S_ADDR_WIDTH-1:0]         DOUT_ADDR,
    output logic                              DOUT_VALID,
    output logic                              DOUT_TLAST,
    input  logic                              DOUT_ACCEP,
    output logic                              FRAME_DONE,
    output logic [C_S_ADDR_WIDTH:0]           FRAME_LEN,
    output logic                              OVERFLOW,
    output logic                              STRB_ERR
);
    localparam int W  = C_S_AXIS_TDATA_WIDTH;
    localparam int NB = W / 8;
    localparam int PW = $clog2(C_S_FIFO_DEPTH);
    localparam int AW = C_S_ADDR_WIDTH;
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(C_S_FIFO_DEPTH);
    localparam logic [AW-1:0] ADDR_MAX = AW'(C_S_MAX_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN} state_t;

    state_t          r_state;
    logic [W:0]      r_mem [C_S_FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_count;
    logic [AW-1:0]   r_addr;
    logic [AW:0]     r_wcnt;
    logic [AW:0]     r_frame_len;
    logic            r_frame_done;
    logic            r_overflow;

    logic            w_wr;
    logic            w_rd;
    logic            w_empty;
    logic [W-1:0]    w_wdata;
    logic [W:0]      w_head;
    logic [AW:0]     w_wcnt_inc;

    assign w_empty       = (r_count == '0);
    assign S_AXIS_TREADY = (r_state == S_RECV) && (r_count < FULL_CNT);
    assign w_wr          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign DOUT_VALID    = !w_empty;
    assign w_rd          = DOUT_VALID && DOUT_ACCEP;
    assign w_head        = w_empty ? '0 : r_mem[r_rptr];
    assign DOUT_DATA     = w_head[W-1:0];
    assign DOUT_TLAST    = w_head[W];
    assign DOUT_ADDR     = r_addr;
    assign FRAME_DONE    = r_frame_done;
    assign FRAME_LEN     = r_frame_len;
    assign OVERFLOW      = r_overflow;
    assign w_wcnt_inc    = (r_wcnt == '1) ? r_wcnt : r_wcnt + 1'b1;

`ifdef AXIS_BRAM_ADAPTER_S00_TSTRB_MASK_EN
    logic r_strb_err;

    always_comb begin
        w_wdata = S_AXIS_TDATA;
        for (int b = 0; b < NB; b++) begin
            if (!S_AXIS_TSTRB[b]) begin
                w_wdata[b*8 +: 8] = 8'h00;
            end
        end
    end

    // Partial strobes are only legitimate on the closing beat of a frame.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_strb_err <= 1'b0;
        end else if (w_wr && !S_AXIS_TLAST && (S_AXIS_TSTRB != '1)) begin
            r_strb_err <= 1'b1;
        end
    end

    assign STRB_ERR = r_strb_err;
`else
    logic w_unused_strb;

    assign w_wdata       = S_AXIS_TDATA;
    assign w_unused_strb = ^S_AXIS_TSTRB;
    assign STRB_ERR      = 1'b0;
`endif

    // Storage is not reset; emptiness is tracked by r_count and gates the outputs.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {S_AXIS_TLAST, w_wdata};
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wcnt       <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE:  r_state <= S_RECV;
                S_RECV:  if (w_wr && S_AXIS_TLAST) r_state <= S_DRAIN;
                S_DRAIN: if (w_rd && DOUT_TLAST) r_state <= S_RECV;
                default: r_state <= S_IDLE;
            endcase
            if (w_rd) begin
                if (DOUT_TLAST) begin
                    r_addr       <= '0;
                    r_wcnt       <= '0;
                    r_frame_len  <= w_wcnt_inc;
                    r_frame_done <= 1'b1;
                end else begin
                    r_wcnt <= w_wcnt_inc;
                    if (r_addr == ADDR_MAX) begin
                        r_addr     <= '0;
                        r_overflow <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_bram_adapter_v1_0_s00_axis.sv
// Bench for axis_bram_adapter_v1_0_s00_axis: directed frames plus random traffic against a queue-based reference.
module tb_axis_bram_adapter_v1_0_s00_axis;
`ifdef AXIS_BRAM_ADAPTER_S00_TSTRB_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif
    localparam int MAXW  = 8;
    localparam int DEPTH = 4;

    logic        S_AXIS_ACLK = 1'b0;
    logic        S_AXIS_ARESET = 1'b0;
    logic [31:0] S_AXIS_TDATA = '0;
    logic [3:0]  S_AXIS_TSTRB = 4'hF;
    logic        S_AXIS_TLAST = 1'b0;
    logic        S_AXIS_TVALID = 1'b0;
    logic        S_AXIS_TREADY;
    logic [31:0] DOUT_DATA;
    logic [9:0]  DOUT_ADDR;
    logic        DOUT_VALID;
    logic        DOUT_TLAST;
    logic        DOUT_ACCEP = 1'b0;
    logic        FRAME_DONE;
    logic [10:0] FRAME_LEN;
    logic        OVERFLOW;
    logic        STRB_ERR;

    axis_bram_adapter_v1_0_s00_axis #(
        .C_S_AXIS_TDATA_WIDTH(32), .C_S_FIFO_DEPTH(DEPTH),
        .C_S_ADDR_WIDTH(10), .C_S_MAX_WORDS(MAXW)
    ) dut (
        .S_AXIS_ACLK(S_AXIS_ACLK), .S_AXIS_ARESET(S_AXIS_ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .DOUT_DATA(DOUT_DATA),
        .DOUT_ADDR(DOUT_ADDR), .DOUT_VALID(DOUT_VALID),
        .DOUT_TLAST(DOUT_TLAST), .DOUT_ACCEP(DOUT_ACCEP),
        .FRAME_DONE(FRAME_DONE), .FRAME_LEN(FRAME_LEN),
        .OVERFLOW(OVERFLOW), .STRB_ERR(STRB_ERR)
    );

    always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_done_seen = 0;

    // Beats waiting to be offered by the source.
    logic [31:0] src_d[$];
    logic [3:0]  src_s[$];
    logic        src_l[$];

    // Reference: words accepted but not yet consumed, plus per-frame bookkeeping.
    logic [31:0] m_q_d[$];
    logic        m_q_l[$];
    bit          m_idle, m_drain, m_done, m_ovf, m_serr;
    int          m_addr, m_cnt, m_len;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] masked(logic [31:0] d, logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return MASK_EN ? (d & m) : d;
    endfunction

    task automatic model_reset();
        m_q_d.delete(); m_q_l.delete();
        src_d.delete(); src_s.delete(); src_l.delete();
        m_idle = 1'b1; m_drain = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_serr = 1'b0;
        m_addr = 0; m_cnt = 0; m_len = 0;
    endtask

    task automatic add_beat(logic [31:0] d, logic [3:0] s, logic l);
        src_d.push_back(d); src_s.push_back(s); src_l.push_back(l);
    endtask

    task automatic chk_zero(string pfx);
        chk({pfx, "_tready"}, S_AXIS_TREADY, 0);
        chk({pfx, "_dvalid"}, DOUT_VALID, 0);
        chk({pfx, "_ddata"}, DOUT_DATA, 0);
        chk({pfx, "_dlast"}, DOUT_TLAST, 0);
        chk({pfx, "_daddr"}, DOUT_ADDR, 0);
        chk({pfx, "_fdone"}, FRAME_DONE, 0);
        chk({pfx, "_flen"}, FRAME_LEN, 0);
        chk({pfx, "_ovf"}, OVERFLOW, 0);
        chk({pfx, "_serr"}, STRB_ERR, 0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model across the rising edge.
    task automatic step(output bit acc);
        bit          exp_rdy, exp_v, hs, nd, l;
        logic [31:0] d;
        logic [3:0]  s;
        logic        tl;
        @(negedge S_AXIS_ACLK);
        exp_rdy = !m_idle && !m_drain && (m_q_d.size() < DEPTH);
        exp_v   = (m_q_d.size() != 0);
        chk("tready", S_AXIS_TREADY, exp_rdy);
        chk("dout_valid", DOUT_VALID, exp_v);
        chk("dout_data", DOUT_DATA, exp_v ? m_q_d[0] : 32'h0);
        chk("dout_tlast", DOUT_TLAST, exp_v ? m_q_l[0] : 1'b0);
        chk("dout_addr", DOUT_ADDR, m_addr);
        chk("frame_done", FRAME_DONE, m_done);
        chk("frame_len", FRAME_LEN, m_len);
        chk("overflow", OVERFLOW, m_ovf);
        chk("strb_err", STRB_ERR, m_serr);
        if (FRAME_DONE) n_done_seen++;
        acc = S_AXIS_TVALID && exp_rdy;
        hs  = exp_v && DOUT_ACCEP;
        d = S_AXIS_TDATA; s = S_AXIS_TSTRB; tl = S_AXIS_TLAST;
        @(posedge S_AXIS_ACLK);
        nd = 1'b0;
        m_idle = 1'b0;
        if (hs) begin
            l = m_q_l.pop_front();
            void'(m_q_d.pop_front());
            m_cnt++;
            if (l) begin
                m_len = m_cnt; m_cnt = 0; m_addr = 0; m_drain = 1'b0; nd = 1'b1;
            end else begin
                m_addr = (m_addr + 1) % MAXW;
                if (m_addr == 0) m_ovf = 1'b1;
            end
        end
        if (acc) begin
            m_q_d.push_back(masked(d, s));
            m_q_l.push_back(tl);
            if (MASK_EN && !tl && s != 4'hF) m_serr = 1'b1;
            if (tl) m_drain = 1'b1;
        end
        m_done = nd;
        #1;
    endtask

    task automatic run(int vpct, int apct, int ncyc, bit until_done);
        bit acc;
        for (int c = 0; c < ncyc; c++) begin
            if (until_done && src_d.size() == 0 && m_q_d.size() == 0 && !m_drain && !m_done) return;
            if (!S_AXIS_TVALID && src_d.size() != 0 && $urandom_range(99) < vpct) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = src_d[0];
                S_AXIS_TSTRB  = src_s[0];
                S_AXIS_TLAST  = src_l[0];
            end
            DOUT_ACCEP = ($urandom_range(99) < apct);
            step(acc);
            if (acc) begin
                void'(src_d.pop_front()); void'(src_s.pop_front()); void'(src_l.pop_front());
                n_acc++;
                S_AXIS_TVALID = 1'b0;
            end
        end
        if (until_done) chk("run_timeout", src_d.size() + m_q_d.size(), 0);
    endtask

    initial begin
        int base_acc, base_done, len;
        model_reset();
        #2 S_AXIS_ARESET = 1'b1;
        repeat (2) @(posedge S_AXIS_ACLK);
        #1 chk_zero("reset");
        S_AXIS_ARESET = 1'b0;

        // Four beats, sink always ready.
        base_done = n_done_seen;
        add_beat(32'h11, 4'hF, 0); add_beat(32'h22, 4'hF, 0);
        add_beat(32'h33, 4'hF, 0); add_beat(32'h44, 4'hF, 1);
        run(100, 100, 40, 1);
        chk("t1_done_pulses", n_done_seen - base_done, 1);
        chk("t1_frame_len", FRAME_LEN, 4);

        // Sink stalled: exactly FIFO depth beats get in, then drain in order.
        for (int i = 0; i < 6; i++) add_beat($urandom, 4'hF, i == 5);
        base_acc = n_acc;
        run(100, 0, 8, 0);
        chk("t2_acc_stalled", n_acc - base_acc, DEPTH);
        run(100, 100, 60, 1);
        chk("t2_frame_len", FRAME_LEN, 6);

        // Back-to-back frames of 3 and 1.
        base_done = n_done_seen;
        for (int i = 0; i < 3; i++) add_beat($urandom, 4'hF, i == 2);
        add_beat($urandom, 4'hF, 1);
        run(100, 100, 40, 1);
        chk("t3_done_pulses", n_done_seen - base_done, 2);
        chk("t3_frame_len", FRAME_LEN, 1);

        // Ten words into an eight-word window: address wraps, overflow sticks.
        for (int i = 0; i < 10; i++) add_beat($urandom, 4'hF, i == 9);
        run(100, 100, 80, 1);
        chk("t4_overflow", OVERFLOW, 1);
        chk("t4_frame_len", FRAME_LEN, 10);

        // Reset with three entries buffered.
        for (int i = 0; i < 5; i++) add_beat($urandom, 4'hF, i == 4);
        base_acc = n_acc;
        run(100, 0, 3, 0);
        chk("t5_buffered", n_acc - base_acc, 3);
        chk("t5_dvalid_pre", DOUT_VALID, 1);
        S_AXIS_ARESET = 1'b1;
        #1 chk_zero("midreset");
        S_AXIS_TVALID = 1'b0;
        DOUT_ACCEP = 1'b0;
        model_reset();
        @(posedge S_AXIS_ACLK);
        #1 S_AXIS_ARESET = 1'b0;
        add_beat($urandom, 4'hF, 0); add_beat($urandom, 4'hF, 1);
        run(100, 100, 40, 1);
        chk("t5_frame_len", FRAME_LEN, 2);

        // Partial strobe on a non-last beat.
        add_beat(32'hAABBCCDD, 4'b0101, 0); add_beat(32'h12345678, 4'hF, 1);
        run(100, 0, 2, 0);
        chk("t6_strb_data", DOUT_DATA, MASK_EN ? 32'h00BB00DD : 32'hAABBCCDD);
        run(100, 100, 40, 1);
        chk("t6_strb_err", STRB_ERR, MASK_EN);

        // Random frames with random source gaps and sink stalls.
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(12, 1);
            for (int i = 0; i < len; i++)
                add_beat($urandom, ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF, i == len - 1);
            run($urandom_range(100, 30), $urandom_range(100, 20), 400, 1);
            chk("rand_frame_len", FRAME_LEN, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
